// File: rtl/adler32_ctrl.sv
// Adler-32 job sequencer: takes a byte count, then that many bytes, and
// emits {B,A} with a single-cycle valid pulse.
module adler32_ctrl #(
  parameter int unsigned SIZE_W  = 32,
  parameter int unsigned MODULUS = 65521
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [SIZE_W-1:0] size,
  input  logic              size_valid,
  output logic              size_ready,
  input  logic [7:0]        data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [31:0]       checksum,
  output logic              checksum_valid
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [16:0] Mod = 17'(MODULUS);

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] count_q, count_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       checksum_q, checksum_d;

  logic [16:0] a_sum, b_sum;
  logic [15:0] a_mod, b_mod;

  // Both accumulators stay below the modulus, so one subtract per stage suffices.
  always_comb begin
    a_sum = {1'b0, a_q} + {9'b0, data};
    a_mod = 16'((a_sum >= Mod) ? (a_sum - Mod) : a_sum);
    b_sum = {1'b0, b_q} + {1'b0, a_mod};
    b_mod = 16'((b_sum >= Mod) ? (b_sum - Mod) : b_sum);
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    a_d            = a_q;
    b_d            = b_q;
    checksum_d     = checksum_q;
    size_ready     = 1'b0;
    data_ready     = 1'b0;
    checksum_valid = 1'b0;
    case (state_q)
      StIdle: begin
        size_ready = 1'b1;
        if (size_valid) begin
          count_d = size;
          a_d     = 16'd1;
          b_d     = 16'd0;
          if (size == '0) begin
            state_d    = StDone;
            checksum_d = 32'h0000_0001;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        data_ready = 1'b1;
        if (data_valid) begin
          a_d     = a_mod;
          b_d     = b_mod;
          count_d = count_q - SIZE_W'(1);
          if (count_q == SIZE_W'(1)) begin
            state_d    = StDone;
            checksum_d = {b_mod, a_mod};
          end
        end
      end
      StDone: begin
        checksum_valid = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      a_q        <= 16'd1;
      b_q        <= 16'd0;
      checksum_q <= 32'h0000_0001;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;

endmodule

// File: tb/tb_adler32_ctrl.sv
// Scoreboard bench for adler32_ctrl: stimulus pushes expected checksums,
// a negedge monitor pops and compares on every checksum_valid pulse.
module tb_adler32_ctrl;

  logic        clock;
  logic        rst;
  logic [31:0] size;
  logic        size_valid;
  logic        size_ready;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] checksum;
  logic        checksum_valid;

  adler32_ctrl #(
    .SIZE_W (32),
    .MODULUS(65521)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .size          (size),
    .size_valid    (size_valid),
    .size_ready    (size_ready),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .checksum      (checksum),
    .checksum_valid(checksum_valid)
  );

  typedef struct {
    logic [31:0] val;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no handshake required handshake within budget", name);
  endtask

  // Reference: plain Adler-32 definition with modulo arithmetic.
  function automatic logic [31:0] adler_ref(input byte unsigned q[$]);
    int unsigned a = 1;
    int unsigned b = 0;
    foreach (q[i]) begin
      a = (a + q[i]) % 65521;
      b = (b + a) % 65521;
    end
    return (b << 16) | a;
  endfunction

  always @(negedge clock) begin
    if (checksum_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got pulse with %h required no pulse", checksum);
      end else begin
        mon_e = sb.pop_front();
        check("checksum", checksum, mon_e.val);
        check("pulse_cycle", cyc, mon_e.due);
        check("readies_in_done", {30'd0, size_ready, data_ready}, 32'd0);
      end
    end
    if (dut.a_q >= 16'd65521 || dut.b_q >= 16'd65521) begin
      miscompares++;
      $display("FAIL acc_range: got A=%h B=%h required both < fff1", dut.a_q, dut.b_q);
    end
  end

  task automatic send_size(input logic [31:0] n, output int unsigned acc);
    int unsigned budget = 0;
    size       = n;
    size_valid = 1'b1;
    @(negedge clock);
    while (!size_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!size_ready) timeout_fail("size_handshake");
    acc = cyc + 1;
    @(posedge clock);
    #1;
    size_valid = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic send_byte(input byte unsigned d, input bit noise, output int unsigned acc);
    int unsigned budget = 0;
    data       = d;
    data_valid = 1'b1;
    if (noise) begin
      size       = $urandom;
      size_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    while (!data_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!data_ready) timeout_fail("data_handshake");
    acc = cyc + 1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    size_valid = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 two idle cycles, 2 random 0..3 idle cycles.
  task automatic run_job(input byte unsigned q[$], input int gap_mode, input bit noise,
                         input bit use_k, input logic [31:0] k);
    int unsigned c;
    int unsigned g;
    exp_t        e;
    e.val = use_k ? k : adler_ref(q);
    if (noise) begin
      data       = 8'($urandom);
      data_valid = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clock);
        #1;
      end
    end
    send_size(q.size(), c);
    if (q.size() == 0) begin
      e.due = c;
      sb.push_back(e);
    end
    foreach (q[i]) begin
      if (i > 0) begin
        g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? $urandom_range(0, 3) : 0;
        repeat (g) begin
          @(negedge clock);
          check("data_ready_run", {31'd0, data_ready}, 32'd1);
          @(posedge clock);
          #1;
        end
      end
      send_byte(q[i], noise, c);
      if (i == q.size() - 1) begin
        e.due = c;
        sb.push_back(e);
      end
    end
  endtask

  function automatic void str_q(input string s, output byte unsigned q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic check_idle(input string tag);
    @(negedge clock);
    check({tag, "_checksum"}, checksum, 32'h0000_0001);
    check({tag, "_size_ready"}, {31'd0, size_ready}, 32'd1);
    check({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    check({tag, "_valid"}, {31'd0, checksum_valid}, 32'd0);
  endtask

  initial begin
    byte unsigned q[$];
    int unsigned  c;
    int unsigned  budget;
    rst        = 1'b1;
    size       = '0;
    size_valid = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    @(posedge clock);
    #1;
    check_idle("reset");
    @(posedge clock);
    #1;
    rst = 1'b0;

    q = {8'h61};
    run_job(q, 0, 1'b0, 1'b1, 32'h0062_0062);

    str_q("abc", q);
    run_job(q, 1, 1'b0, 1'b1, 32'h024D_0127);

    str_q("Wikipedia", q);
    run_job(q, 0, 1'b0, 1'b1, 32'h11E6_0398);
    q = {};
    run_job(q, 0, 1'b0, 1'b1, 32'h0000_0001);

    q = {};
    for (int i = 0; i < 5600; i++) q.push_back(8'hFF);
    run_job(q, 0, 1'b0, 1'b0, 32'h0);

    // Abort a 4-byte job after two bytes.
    send_size(32'd4, c);
    send_byte(8'h10, 1'b0, c);
    send_byte(8'h20, 1'b0, c);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    check_idle("abort");
    @(posedge clock);
    #1;
    q = {8'h61};
    run_job(q, 0, 1'b0, 1'b1, 32'h0062_0062);

    str_q("abc", q);
    run_job(q, 2, 1'b1, 1'b1, 32'h024D_0127);
    str_q("Wikipedia", q);
    run_job(q, 2, 1'b1, 1'b1, 32'h11E6_0398);

    for (int j = 0; j < 20; j++) begin
      q = {};
      repeat ($urandom_range(0, 40)) q.push_back(8'($urandom));
      run_job(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    if (sb.size() != 0) timeout_fail("pending_checksum");
    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
